// File: rtl/vec_pkg.sv
// Shared types and constants for the vector issue sequencer and the 4-lane vector ALU.
package vec_pkg;

    localparam int unsigned VLEN          = 128;
    localparam int unsigned ELEN          = 32;
    localparam int unsigned NUM_VEC_LANES = VLEN / ELEN;
    localparam int unsigned NUM_VEC_REGS  = 32;
    localparam int unsigned TAG_W         = 6;
    localparam int unsigned REG_W         = $clog2(NUM_VEC_REGS);
    localparam int unsigned OP_W          = 4;
    localparam int unsigned VL_W          = 32;
    localparam int unsigned LMUL_W        = 2;
    localparam int unsigned IDX_W         = 3;
    localparam int unsigned VLMAX_GROUP   = 8 * NUM_VEC_LANES;
    localparam int unsigned LANE_IDX_W    = $clog2(NUM_VEC_LANES);
    // wide enough to hold VLMAX_GROUP itself (0..32)
    localparam int unsigned VL_EFF_W      = $clog2(VLMAX_GROUP) + 1;

    typedef enum logic [OP_W-1:0] {
        VOP_ADD = 4'd0,
        VOP_SUB = 4'd1,
        VOP_AND = 4'd2,
        VOP_OR  = 4'd3,
        VOP_XOR = 4'd4,
        VOP_MIN = 4'd5,
        VOP_MAX = 4'd6,
        VOP_SLL = 4'd7,
        VOP_SRL = 4'd8
    } vec_op_e;

    typedef enum logic [LMUL_W-1:0] {
        LMUL_1 = 2'd0,
        LMUL_2 = 2'd1,
        LMUL_4 = 2'd2,
        LMUL_8 = 2'd3
    } lmul_e;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_ISSUE = 2'd1,
        SEQ_WAIT  = 2'd2,
        SEQ_DONE  = 2'd3
    } seq_state_e;

    // incoming decoded request
    typedef struct packed {
        logic [REG_W-1:0] vd;
        logic [REG_W-1:0] vs1;
        logic [REG_W-1:0] vs2;
        logic [OP_W-1:0]  op;
        logic [VL_W-1:0]  vl;
        lmul_e            lmul;
        logic [TAG_W-1:0] tag;
    } seq_req_t;

    // per-instruction context held for the whole group walk
    typedef struct packed {
        logic [REG_W-1:0]    vd;
        logic [REG_W-1:0]    vs1;
        logic [REG_W-1:0]    vs2;
        logic [OP_W-1:0]     op;
        logic [VL_EFF_W-1:0] vl_eff;
        logic [IDX_W-1:0]    last_idx;
        logic [TAG_W-1:0]    tag;
        logic                illegal;
    } seq_ctx_t;

    // elements held by a register group of the given LMUL
    function automatic logic [VL_EFF_W-1:0] group_capacity(input lmul_e lmul);
        return VL_EFF_W'(NUM_VEC_LANES) << lmul;
    endfunction

    // low register-number bits that must be zero for a group-aligned base
    function automatic logic [REG_W-1:0] group_align_mask(input lmul_e lmul);
        return (REG_W'(1) << lmul) - REG_W'(1);
    endfunction

endpackage

// File: rtl/vec_tail_mask_gen.sv
// Per-element write enables for one register of a group: live elements below vl_eff.
module vec_tail_mask_gen
    import vec_pkg::*;
(
    input  logic [IDX_W-1:0]         idx,
    input  logic [VL_EFF_W-1:0]      vl_eff,
    output logic [NUM_VEC_LANES-1:0] elem_en
);

    // group-wide element index is {idx, lane}; compare against the effective length
    always_comb begin
        for (int unsigned j = 0; j < NUM_VEC_LANES; j++) begin
            elem_en[j] = VL_EFF_W'({idx, LANE_IDX_W'(j)}) < vl_eff;
        end
    end

endmodule

// File: rtl/vector_issue_sequencer.sv
// Steps one RVV element-wise op through its register group: read, issue, await, masked write.
module vector_issue_sequencer
    import vec_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [REG_W-1:0]         req_vd,
    input  logic [REG_W-1:0]         req_vs1,
    input  logic [REG_W-1:0]         req_vs2,
    input  logic [OP_W-1:0]          req_op,
    input  logic [VL_W-1:0]          req_vl,
    input  logic [LMUL_W-1:0]        req_lmul,
    input  logic [TAG_W-1:0]         req_tag,
    output logic [REG_W-1:0]         vrf_rd_addr1,
    output logic [REG_W-1:0]         vrf_rd_addr2,
    input  logic [VLEN-1:0]          vrf_rd_data1,
    input  logic [VLEN-1:0]          vrf_rd_data2,
    output logic [VLEN-1:0]          veu_src1,
    output logic [VLEN-1:0]          veu_src2,
    output logic [OP_W-1:0]          veu_op,
    output logic                     veu_valid,
    input  logic [VLEN-1:0]          veu_result,
    input  logic                     veu_result_valid,
    output logic                     vrf_wr_en,
    output logic [REG_W-1:0]         vrf_wr_addr,
    output logic [VLEN-1:0]          vrf_wr_data,
    output logic [NUM_VEC_LANES-1:0] vrf_wr_elem_en,
    output logic                     done_valid,
    output logic [TAG_W-1:0]         done_tag,
    output logic                     done_illegal,
    output logic                     busy
);

    seq_state_e               state_q;
    seq_state_e               state_d;
    logic [IDX_W-1:0]         idx_q;
    logic [IDX_W-1:0]         idx_d;
    seq_ctx_t                 ctx_q;
    seq_ctx_t                 req_ctx;
    seq_req_t                 req;
    logic                     accept;
    logic [VL_EFF_W-1:0]      cap;
    logic [VL_EFF_W-1:0]      num_members;
    logic [NUM_VEC_LANES-1:0] elem_en;

    assign accept = req_valid && (state_q == SEQ_IDLE);

    // decode the incoming request into the context that is latched on acceptance
    always_comb begin
        req = '{vd:   req_vd,
                vs1:  req_vs1,
                vs2:  req_vs2,
                op:   req_op,
                vl:   req_vl,
                lmul: lmul_e'(req_lmul),
                tag:  req_tag};

        cap = group_capacity(req.lmul);

        req_ctx          = '0;
        req_ctx.vd       = req.vd;
        req_ctx.vs1      = req.vs1;
        req_ctx.vs2      = req.vs2;
        req_ctx.op       = req.op;
        req_ctx.tag      = req.tag;
        req_ctx.vl_eff   = (req.vl < VL_W'(cap)) ? VL_EFF_W'(req.vl) : cap;
        req_ctx.illegal  = |((req.vd | req.vs1 | req.vs2) & group_align_mask(req.lmul));

        num_members      = (req_ctx.vl_eff + VL_EFF_W'(NUM_VEC_LANES - 1)) >> LANE_IDX_W;
        // meaningless when vl_eff==0, but that case never leaves IDLE through ISSUE
        req_ctx.last_idx = IDX_W'(num_members - VL_EFF_W'(1));
    end

    // request context capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctx_q <= '0;
        end else if (accept) begin
            ctx_q <= req_ctx;
        end
    end

    // state and member index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEQ_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // next-state and strobe decode
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        req_ready  = 1'b0;
        busy       = 1'b1;
        veu_valid  = 1'b0;
        vrf_wr_en  = 1'b0;
        done_valid = 1'b0;

        case (state_q)
            SEQ_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                idx_d     = '0;
                if (req_valid) begin
                    if (req_ctx.illegal || (req_ctx.vl_eff == '0)) begin
                        state_d = SEQ_DONE;
                    end else begin
                        state_d = SEQ_ISSUE;
                    end
                end
            end
            SEQ_ISSUE: begin
                veu_valid = 1'b1;
                state_d   = SEQ_WAIT;
            end
            SEQ_WAIT: begin
                if (veu_result_valid) begin
                    vrf_wr_en = 1'b1;
                    if (idx_q == ctx_q.last_idx) begin
                        state_d = SEQ_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = SEQ_ISSUE;
                    end
                end
            end
            SEQ_DONE: begin
                done_valid = 1'b1;
                state_d    = SEQ_IDLE;
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    vec_tail_mask_gen u_tail_mask (
        .idx     (idx_q),
        .vl_eff  (ctx_q.vl_eff),
        .elem_en (elem_en)
    );

    // datapath routing; group sums cannot wrap because bases are group-aligned
    assign vrf_rd_addr1   = ctx_q.vs1 + REG_W'(idx_q);
    assign vrf_rd_addr2   = ctx_q.vs2 + REG_W'(idx_q);
    assign veu_src1       = vrf_rd_data1;
    assign veu_src2       = vrf_rd_data2;
    assign veu_op         = ctx_q.op;
    assign vrf_wr_addr    = ctx_q.vd + REG_W'(idx_q);
    assign vrf_wr_data    = veu_result;
    assign vrf_wr_elem_en = elem_en & {NUM_VEC_LANES{vrf_wr_en}};
    assign done_tag       = ctx_q.tag;
    assign done_illegal   = ctx_q.illegal;

endmodule

// File: tb/tb_vector_issue_sequencer.sv
// Directed bench: table of ops with hand-computed results plus reset/spurious-strobe sequences.
module tb_vector_issue_sequencer;
    import vec_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     req_valid = 1'b0;
    logic                     req_ready;
    logic [4:0]               req_vd = '0;
    logic [4:0]               req_vs1 = '0;
    logic [4:0]               req_vs2 = '0;
    logic [3:0]               req_op = '0;
    logic [31:0]              req_vl = '0;
    logic [1:0]               req_lmul = '0;
    logic [5:0]               req_tag = '0;
    logic [4:0]               vrf_rd_addr1;
    logic [4:0]               vrf_rd_addr2;
    logic [VLEN-1:0]          vrf_rd_data1;
    logic [VLEN-1:0]          vrf_rd_data2;
    logic [VLEN-1:0]          veu_src1;
    logic [VLEN-1:0]          veu_src2;
    logic [3:0]               veu_op;
    logic                     veu_valid;
    logic [VLEN-1:0]          veu_result;
    logic                     veu_result_valid;
    logic                     vrf_wr_en;
    logic [4:0]               vrf_wr_addr;
    logic [VLEN-1:0]          vrf_wr_data;
    logic [NUM_VEC_LANES-1:0] vrf_wr_elem_en;
    logic                     done_valid;
    logic [5:0]               done_tag;
    logic                     done_illegal;
    logic                     busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vector_issue_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_vd           (req_vd),
        .req_vs1          (req_vs1),
        .req_vs2          (req_vs2),
        .req_op           (req_op),
        .req_vl           (req_vl),
        .req_lmul         (req_lmul),
        .req_tag          (req_tag),
        .vrf_rd_addr1     (vrf_rd_addr1),
        .vrf_rd_addr2     (vrf_rd_addr2),
        .vrf_rd_data1     (vrf_rd_data1),
        .vrf_rd_data2     (vrf_rd_data2),
        .veu_src1         (veu_src1),
        .veu_src2         (veu_src2),
        .veu_op           (veu_op),
        .veu_valid        (veu_valid),
        .veu_result       (veu_result),
        .veu_result_valid (veu_result_valid),
        .vrf_wr_en        (vrf_wr_en),
        .vrf_wr_addr      (vrf_wr_addr),
        .vrf_wr_data      (vrf_wr_data),
        .vrf_wr_elem_en   (vrf_wr_elem_en),
        .done_valid       (done_valid),
        .done_tag         (done_tag),
        .done_illegal     (done_illegal),
        .busy             (busy)
    );

    // ---------------- environment: VRF and ALU models ----------------
    logic [VLEN-1:0]          vrf     [NUM_VEC_REGS];
    int                       wr_cnt  [NUM_VEC_REGS];
    logic [NUM_VEC_LANES-1:0] last_en [NUM_VEC_REGS];
    int                       total_wr = 0;
    logic                     init_req = 1'b0;

    function automatic logic [VLEN-1:0] init_val(input int r);
        logic [VLEN-1:0] v;
        for (int j = 0; j < NUM_VEC_LANES; j++)
            v[j*ELEN +: ELEN] = 32'(r) * 32'h0100_0000 + 32'(j) * 32'h10 + 32'h5;
        return v;
    endfunction

    function automatic logic [VLEN-1:0] alu_f(input logic [3:0] op, input logic [VLEN-1:0] a,
                                              input logic [VLEN-1:0] b);
        logic [VLEN-1:0] r;
        for (int j = 0; j < NUM_VEC_LANES; j++) begin
            case (op)
                VOP_ADD: r[j*ELEN +: ELEN] = a[j*ELEN +: ELEN] + b[j*ELEN +: ELEN];
                VOP_SUB: r[j*ELEN +: ELEN] = a[j*ELEN +: ELEN] - b[j*ELEN +: ELEN];
                VOP_AND: r[j*ELEN +: ELEN] = a[j*ELEN +: ELEN] & b[j*ELEN +: ELEN];
                VOP_OR:  r[j*ELEN +: ELEN] = a[j*ELEN +: ELEN] | b[j*ELEN +: ELEN];
                VOP_XOR: r[j*ELEN +: ELEN] = a[j*ELEN +: ELEN] ^ b[j*ELEN +: ELEN];
                default: r[j*ELEN +: ELEN] = a[j*ELEN +: ELEN];
            endcase
        end
        return r;
    endfunction

    function automatic logic [VLEN-1:0] merge(input logic [VLEN-1:0] old_v, input logic [VLEN-1:0] new_v,
                                              input logic [3:0] m);
        logic [VLEN-1:0] r;
        for (int j = 0; j < NUM_VEC_LANES; j++)
            r[j*ELEN +: ELEN] = m[j] ? new_v[j*ELEN +: ELEN] : old_v[j*ELEN +: ELEN];
        return r;
    endfunction

    assign vrf_rd_data1 = vrf[vrf_rd_addr1];
    assign vrf_rd_data2 = vrf[vrf_rd_addr2];

    // VRF with write logging
    always @(posedge clk) begin
        if (init_req) begin
            for (int r = 0; r < NUM_VEC_REGS; r++) begin
                vrf[r]     <= init_val(r);
                wr_cnt[r]  <= 0;
                last_en[r] <= '0;
            end
            total_wr <= 0;
        end else if (vrf_wr_en) begin
            for (int j = 0; j < NUM_VEC_LANES; j++)
                if (vrf_wr_elem_en[j]) vrf[vrf_wr_addr][j*ELEN +: ELEN] <= vrf_wr_data[j*ELEN +: ELEN];
            wr_cnt[vrf_wr_addr]  <= wr_cnt[vrf_wr_addr] + 1;
            last_en[vrf_wr_addr] <= vrf_wr_elem_en;
            total_wr             <= total_wr + 1;
        end
    end

    // ALU: result strobe 1 + alu_delay cycles after the issue strobe; ignores reset on purpose
    logic            alu_vld  = 1'b0;
    logic            alu_pend = 1'b0;
    logic            spur_vld = 1'b0;
    logic [VLEN-1:0] alu_res  = '0;
    int              alu_cnt  = 0;
    int              alu_delay = 0;

    always @(posedge clk) begin
        alu_vld <= 1'b0;
        if (veu_valid) begin
            alu_res <= alu_f(veu_op, veu_src1, veu_src2);
            if (alu_delay == 0) alu_vld <= 1'b1;
            else begin
                alu_pend <= 1'b1;
                alu_cnt  <= alu_delay;
            end
        end else if (alu_pend) begin
            if (alu_cnt == 1) begin
                alu_vld  <= 1'b1;
                alu_pend <= 1'b0;
            end
            alu_cnt <= alu_cnt - 1;
        end
    end

    assign veu_result       = alu_res;
    assign veu_result_valid = alu_vld | spur_vld;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic do_init();
        @(negedge clk);
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
    endtask

    typedef struct {
        logic [4:0]  vd;
        logic [4:0]  vs1;
        logic [4:0]  vs2;
        logic [3:0]  op;
        logic [31:0] vl;
        logic [1:0]  lmul;
        logic [5:0]  tag;
        int          delay;
        logic        exp_illegal;
        int          exp_writes;
        int          exp_done;
        logic [3:0]  exp_last_en;
    } vec_t;

    // drive one request and wait (bounded) for its completion pulse
    task automatic run_op(input vec_t v, output int cyc, output logic [5:0] tag, output logic ill,
                          output int issues, output int rdy_busy);
        @(negedge clk);
        chk("ready_before_accept", 128'(req_ready), 128'(1));
        req_valid = 1'b1;
        req_vd    = v.vd;
        req_vs1   = v.vs1;
        req_vs2   = v.vs2;
        req_op    = v.op;
        req_vl    = v.vl;
        req_lmul  = v.lmul;
        req_tag   = v.tag;
        alu_delay = v.delay;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        issues = 0;
        rdy_busy = 0;
        while (!done_valid && cyc < 300) begin
            if (veu_valid) issues++;
            if (req_ready) rdy_busy++;
            @(negedge clk);
            cyc++;
        end
        tag = done_tag;
        ill = done_illegal;
        if (!done_valid) cyc = -1;
    endtask

    vec_t tv [12];

    initial begin
        int         cyc;
        int         issues;
        int         rdy_busy;
        int         seen;
        logic [5:0] tag;
        logic       ill;
        bit         found;

        //           vd     vs1    vs2    op       vl      lmul  tag    dly ill   wr done last
        tv[0]  = '{5'd3,  5'd1,  5'd2,  VOP_ADD, 32'd4,   2'd0, 6'd5,  0, 1'b0, 1, 3,  4'hF};
        tv[1]  = '{5'd8,  5'd0,  5'd4,  VOP_SUB, 32'd10,  2'd2, 6'd6,  0, 1'b0, 3, 7,  4'h3};
        tv[2]  = '{5'd1,  5'd2,  5'd3,  VOP_ADD, 32'd0,   2'd0, 6'd7,  0, 1'b0, 0, 1,  4'h0};
        tv[3]  = '{5'd5,  5'd0,  5'd2,  VOP_ADD, 32'd4,   2'd1, 6'd8,  0, 1'b1, 0, 1,  4'h0};
        tv[4]  = '{5'd12, 5'd14, 5'd16, VOP_XOR, 32'd100, 2'd1, 6'd9,  0, 1'b0, 2, 5,  4'hF};
        tv[5]  = '{5'd20, 5'd21, 5'd22, VOP_AND, 32'd3,   2'd0, 6'd10, 3, 1'b0, 1, 6,  4'h7};
        tv[6]  = '{5'd2,  5'd2,  5'd4,  VOP_OR,  32'd8,   2'd1, 6'd11, 0, 1'b0, 2, 5,  4'hF};
        tv[7]  = '{5'd8,  5'd0,  5'd4,  VOP_ADD, 32'd8,   2'd3, 6'd12, 0, 1'b1, 0, 1,  4'h0};
        tv[8]  = '{5'd24, 5'd0,  5'd8,  VOP_ADD, 32'd29,  2'd3, 6'd13, 0, 1'b0, 8, 17, 4'h1};
        tv[9]  = '{5'd0,  5'd8,  5'd16, VOP_SUB, 32'd32,  2'd3, 6'd63, 1, 1'b0, 8, 25, 4'hF};
        tv[10] = '{5'd1,  5'd0,  5'd2,  VOP_ADD, 32'd0,   2'd1, 6'd14, 0, 1'b1, 0, 1,  4'h0};
        tv[11] = '{5'd4,  5'd4,  5'd4,  VOP_ADD, 32'd5,   2'd1, 6'd0,  2, 1'b0, 2, 9,  4'h1};

        // reset state
        do_init();
        @(negedge clk);
        chk("rst_req_ready", 128'(req_ready), 128'(1));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_veu_valid", 128'(veu_valid), 128'(0));
        chk("rst_wr_en", 128'(vrf_wr_en), 128'(0));
        chk("rst_done_valid", 128'(done_valid), 128'(0));
        rst_n = 1'b1;

        // table-driven ops
        for (int i = 0; i < 12; i++) begin
            do_init();
            run_op(tv[i], cyc, tag, ill, issues, rdy_busy);
            chk($sformatf("v%0d_done_cycle", i), 128'(cyc), 128'(tv[i].exp_done));
            chk($sformatf("v%0d_tag", i), 128'(tag), 128'(tv[i].tag));
            chk($sformatf("v%0d_illegal", i), 128'(ill), 128'(tv[i].exp_illegal));
            chk($sformatf("v%0d_issues", i), 128'(issues), 128'(tv[i].exp_writes));
            chk($sformatf("v%0d_ready_while_busy", i), 128'(rdy_busy), 128'(0));
            chk($sformatf("v%0d_ready_in_done", i), 128'(req_ready), 128'(0));
            chk($sformatf("v%0d_total_writes", i), 128'(total_wr), 128'(tv[i].exp_writes));
            if (!tv[i].exp_illegal) begin
                for (int r = 0; r < (1 << tv[i].lmul); r++) begin
                    int               reg_i;
                    logic [3:0]       m;
                    logic [VLEN-1:0]  exp_v;
                    reg_i = int'(tv[i].vd) + r;
                    if (r < tv[i].exp_writes) begin
                        m = (r == tv[i].exp_writes - 1) ? tv[i].exp_last_en : 4'hF;
                        exp_v = merge(init_val(reg_i),
                                      alu_f(tv[i].op, init_val(int'(tv[i].vs1) + r),
                                            init_val(int'(tv[i].vs2) + r)), m);
                        chk($sformatf("v%0d_r%0d_elem_en", i, reg_i), 128'(last_en[reg_i]), 128'(m));
                        chk($sformatf("v%0d_r%0d_wr_cnt", i, reg_i), 128'(wr_cnt[reg_i]), 128'(1));
                    end else begin
                        exp_v = init_val(reg_i);
                        chk($sformatf("v%0d_r%0d_tail_wr_cnt", i, reg_i), 128'(wr_cnt[reg_i]), 128'(0));
                    end
                    chk($sformatf("v%0d_r%0d_data", i, reg_i), vrf[reg_i], exp_v);
                end
            end
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse_1cyc", i), 128'(done_valid), 128'(0));
            chk($sformatf("v%0d_idle_after", i), 128'(busy), 128'(0));
        end

        // spurious ALU strobe while idle
        do_init();
        seen = 0;
        spur_vld = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (vrf_wr_en || busy) seen++;
        end
        spur_vld = 1'b0;
        @(negedge clk);
        chk("spurious_activity", 128'(seen), 128'(0));
        chk("spurious_writes", 128'(total_wr), 128'(0));

        // reset during WAIT of an LMUL=8 op with a result still in flight
        do_init();
        @(negedge clk);
        req_valid = 1'b1;
        req_vd    = 5'd0;
        req_vs1   = 5'd8;
        req_vs2   = 5'd16;
        req_op    = VOP_ADD;
        req_vl    = 32'd32;
        req_lmul  = 2'd3;
        req_tag   = 6'd33;
        alu_delay = 2;
        @(negedge clk);
        req_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            if (veu_valid && total_wr == 1) found = 1'b1;
            else @(negedge clk);
        end
        chk("mid_reset_reached_second_issue", 128'(found), 128'(1));
        @(negedge clk);
        chk("mid_reset_in_wait", 128'({busy, veu_valid, vrf_wr_en}), 128'(3'b100));
        rst_n = 1'b0;
        #1;
        chk("mid_reset_busy", 128'(busy), 128'(0));
        chk("mid_reset_ready", 128'(req_ready), 128'(1));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done_valid || vrf_wr_en || busy) seen++;
        end
        chk("post_reset_activity", 128'(seen), 128'(0));
        chk("post_reset_writes", 128'(total_wr), 128'(1));
        chk("post_reset_v1_untouched", 128'(wr_cnt[1]), 128'(0));

        // next request completes normally
        run_op(tv[0], cyc, tag, ill, issues, rdy_busy);
        chk("after_reset_done_cycle", 128'(cyc), 128'(3));
        chk("after_reset_tag", 128'(tag), 128'(5));
        chk("after_reset_writes", 128'(total_wr), 128'(2));
        chk("after_reset_v3", vrf[3], alu_f(VOP_ADD, init_val(1), init_val(2)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
